fft_frame_ctrl: RTL and testbench

//  Frame sequencer in front of the pipelined radix-2 FFT core. Accepts a valid/ready sample stream and

---
 rtl/fft_frame_ctrl.sv | 150 +++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer in front of a pipelined radix-2 FFT core: gates a valid/ready sample stream into
// contiguous 2^NALL-sample frames and tracks frames in flight from the core's output tags.
module fft_frame_ctrl #(
    parameter int width = 16,
    parameter int NALL  = 9,
    parameter int MAXF  = 4
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    start,
    input  logic                    cont,
    input  logic                    stop,
    input  logic                    s_valid,
    input  logic signed [width-1:0] s_data,
    output logic                    s_ready,
    output logic                    fft_en,
    output logic [NALL-1:0]         fft_cnt,
    output logic signed [width-1:0] fft_din,
    input  logic                    fft_dout_en,
    input  logic [NALL-1:0]         fft_dout_cnt,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              in_flight,
    output logic [15:0]             frames_out,
    output logic                    seq_err
);

    localparam logic [NALL-1:0] LAST    = '1;
    localparam logic [NALL-1:0] ONE     = NALL'(1);
    localparam logic [3:0]      MAXF_L  = 4'(MAXF);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [NALL-1:0]         cnt_q, cnt_d;
    logic                    stop_q, stop_d;
    logic                    done_q, done_d;
    logic [3:0]              in_flight_q, in_flight_d;
    logic [15:0]             frames_out_q, frames_out_d;
    logic                    seq_err_q, seq_err_d;
    logic                    out_seen_q;
    logic [NALL-1:0]         out_prev_q;
    logic                    fft_en_q;
    logic [NALL-1:0]         fft_cnt_q;
    logic signed [width-1:0] fft_din_q;

    logic            accept;
    logic            last_in;
    logic            last_out;
    logic            stop_eff;
    logic [NALL-1:0] exp_out;

    // Throttle only at a frame boundary so a frame is never split by the controller.
    assign s_ready  = (state_q == ST_FILL) && !((cnt_q == '0) && (in_flight_q == MAXF_L));
    assign accept   = s_valid && s_ready;
    assign last_in  = accept && (cnt_q == LAST);
    assign last_out = fft_dout_en && (fft_dout_cnt == LAST);
    assign stop_eff = stop_q || stop;
    assign exp_out  = out_seen_q ? (out_prev_q + ONE) : '0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stop_d       = stop_q;
        done_d       = 1'b0;
        in_flight_d  = in_flight_q;
        frames_out_d = frames_out_q;
        seq_err_d    = seq_err_q;

        if (last_in && !last_out) begin
            if (in_flight_q != MAXF_L) in_flight_d = in_flight_q + 4'd1;
        end else if (last_out && !last_in) begin
            if (in_flight_q == 4'd0) seq_err_d = 1'b1;
            else                     in_flight_d = in_flight_q - 4'd1;
        end
        if (last_out) frames_out_d = frames_out_q + 16'd1;
        if (fft_dout_en && (fft_dout_cnt != exp_out)) seq_err_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                end
            end
            ST_FILL: begin
                if (stop) stop_d = 1'b1;
                if (accept) begin
                    cnt_d = cnt_q + ONE;
                    if ((cnt_q == LAST) && !(cont && !stop_eff)) state_d = ST_DRAIN;
                end else if (stop_eff && (cnt_q == '0)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (in_flight_d == 4'd0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) stop_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            stop_q       <= 1'b0;
            done_q       <= 1'b0;
            in_flight_q  <= 4'd0;
            frames_out_q <= 16'd0;
            seq_err_q    <= 1'b0;
            out_seen_q   <= 1'b0;
            out_prev_q   <= '0;
            fft_en_q     <= 1'b0;
            fft_cnt_q    <= '0;
            fft_din_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stop_q       <= stop_d;
            done_q       <= done_d;
            in_flight_q  <= in_flight_d;
            frames_out_q <= frames_out_d;
            seq_err_q    <= seq_err_d;
            if (fft_dout_en) begin
                out_seen_q <= 1'b1;
                out_prev_q <= fft_dout_cnt;
            end
            fft_en_q <= accept;
            if (accept) begin
                fft_cnt_q <= cnt_q;
                fft_din_q <= s_data;
            end
        end
    end

    assign fft_en     = fft_en_q;
    assign fft_cnt    = fft_cnt_q;
    assign fft_din    = fft_din_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign in_flight  = in_flight_q;
    assign frames_out = frames_out_q;
    assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl; the bench itself plays the FFT core's output side.
module tb_fft_frame_ctrl;

    logic               clk = 1'b0;
    logic               areset, start, cont, stop, s_valid;
    logic signed [15:0] s_data;
    logic               s_ready, fft_en;
    logic [8:0]         fft_cnt;
    logic signed [15:0] fft_din;
    logic               fft_dout_en;
    logic [8:0]         fft_dout_cnt;
    logic               busy, done;
    logic [3:0]         in_flight;
    logic [15:0]        frames_out;
    logic               seq_err;

    int passes = 0;
    int total  = 0;
    int bad    = 0;

    always #5 clk = ~clk;

    fft_frame_ctrl #(.width(16), .NALL(9), .MAXF(2)) dut (
        .clk(clk), .areset(areset), .start(start), .cont(cont), .stop(stop),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .fft_en(fft_en), .fft_cnt(fft_cnt), .fft_din(fft_din),
        .fft_dout_en(fft_dout_en), .fft_dout_cnt(fft_dout_cnt),
        .busy(busy), .done(done), .in_flight(in_flight),
        .frames_out(frames_out), .seq_err(seq_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One accepted sample: expect it on the core input one cycle later.
    task automatic push(input logic [15:0] d, input logic [8:0] ecnt);
        s_valid = 1'b1;
        s_data  = d;
        step();
        if (fft_en !== 1'b1 || fft_cnt !== ecnt || fft_din !== d) bad++;
        s_valid = 1'b0;
    endtask

    task automatic bin(input logic [8:0] c);
        fft_dout_en  = 1'b1;
        fft_dout_cnt = c;
        step();
        fft_dout_en  = 1'b0;
    endtask

    initial begin
        areset = 1'b1; start = 1'b0; cont = 1'b0; stop = 1'b0; s_valid = 1'b0;
        s_data = '0; fft_dout_en = 1'b0; fft_dout_cnt = '0;
        step(); step();
        areset = 1'b0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_en", fft_en, 0);
        chk("rst_inflight", in_flight, 0);
        chk("rst_frames", frames_out, 0);

        // 1: single frame
        start = 1'b1; step(); start = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_ready", s_ready, 1);
        bad = 0;
        for (int i = 0; i < 512; i++) push(16'(i * 3 + 1), 9'(i));
        chk("t1_stream_bad", bad, 0);
        chk("t1_inflight", in_flight, 1);
        chk("t1_ready_drain", s_ready, 0);
        step();
        chk("t1_en_off", fft_en, 0);
        for (int i = 0; i < 511; i++) bin(9'(i));
        chk("t1_no_early_done", done, 0);
        bin(9'd511);
        chk("t1_done", done, 1);
        chk("t1_idle", busy, 0);
        chk("t1_frames", frames_out, 1);
        chk("t1_inflight0", in_flight, 0);
        step();
        chk("t1_done_pulse", done, 0);

        // 2: gaps from s_valid
        start = 1'b1; step(); start = 1'b0;
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            push(16'(16'h8000 + k * 7), 9'(k));
            s_data = 16'h5555;
            step();
            if (fft_en !== 1'b0 || fft_cnt !== 9'(k) || fft_din !== 16'(16'h8000 + k * 7)) bad++;
        end
        chk("t2_gap_bad", bad, 0);
        for (int i = 0; i < 512; i++) bin(9'(i));
        chk("t2_done", done, 1);
        chk("t2_frames", frames_out, 2);

        // 3: throttle with MAXF=2, core output stalled
        cont = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        bad = 0;
        for (int i = 0; i < 1024; i++) push(16'(i), 9'(i % 512));
        chk("t3_stream_bad", bad, 0);
        chk("t3_inflight", in_flight, 2);
        chk("t3_ready_off", s_ready, 0);
        chk("t3_busy", busy, 1);
        bad = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (fft_en !== 1'b0) bad++;
        end
        s_valid = 1'b0;
        chk("t3_no_accept", bad, 0);
        for (int i = 0; i < 512; i++) bin(9'(i));
        chk("t3_ready_on", s_ready, 1);
        chk("t3_inflight1", in_flight, 1);
        chk("t3_frames", frames_out, 3);

        // 4: last input sample and last output bin on the same edge
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            s_valid = 1'b1; s_data = 16'(k + 100);
            fft_dout_en = 1'b1; fft_dout_cnt = 9'(k);
            step();
            if (fft_en !== 1'b1 || fft_cnt !== 9'(k)) bad++;
        end
        s_valid = 1'b0; fft_dout_en = 1'b0;
        chk("t4_stream_bad", bad, 0);
        chk("t4_inflight", in_flight, 1);
        chk("t4_frames", frames_out, 4);
        chk("t4_busy", busy, 1);

        // 5: stop mid-frame at cnt=100
        bad = 0;
        for (int k = 0; k < 100; k++) push(16'(k), 9'(k));
        stop = 1'b1;
        push(16'd100, 9'd100);
        stop = 1'b0;
        for (int k = 101; k < 512; k++) push(16'(k), 9'(k));
        chk("t5_stream_bad", bad, 0);
        chk("t5_inflight", in_flight, 2);
        chk("t5_ready_off", s_ready, 0);
        bad = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (fft_en !== 1'b0) bad++;
        end
        s_valid = 1'b0;
        chk("t5_no_frame2", bad, 0);
        for (int i = 0; i < 512; i++) bin(9'(i));
        chk("t5_mid_done", done, 0);
        chk("t5_inflight1", in_flight, 1);
        for (int i = 0; i < 512; i++) bin(9'(i));
        chk("t5_done", done, 1);
        chk("t5_frames", frames_out, 6);
        chk("t5_seq_ok", seq_err, 0);

        // 5b: stop at cnt=0 with no accept drains at once
        cont = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        stop = 1'b1; step(); stop = 1'b0;
        chk("t5b_drain_busy", busy, 1);
        chk("t5b_ready_off", s_ready, 0);
        step();
        chk("t5b_done", done, 1);
        chk("t5b_idle", busy, 0);
        chk("t5b_no_sample", fft_en, 0);

        // 6: reset mid-frame, then an output sequence error
        start = 1'b1; step(); start = 1'b0;
        bad = 0;
        for (int k = 0; k < 300; k++) push(16'(k + 9), 9'(k));
        chk("t6_stream_bad", bad, 0);
        areset = 1'b1; s_valid = 1'b1; s_data = 16'h1234;
        step();
        areset = 1'b0; s_valid = 1'b0;
        chk("t6_rst_en", fft_en, 0);
        chk("t6_rst_cnt", fft_cnt, 0);
        chk("t6_rst_din", fft_din, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_frames", frames_out, 0);
        chk("t6_rst_ready", s_ready, 0);
        start = 1'b1; step(); start = 1'b0;
        bad = 0;
        push(16'h0abc, 9'd0);
        chk("t6_restart_bad", bad, 0);
        for (int i = 0; i < 6; i++) bin(9'(i));
        chk("t6_seq_ok", seq_err, 0);
        bin(9'd7);
        chk("t6_seq_err", seq_err, 1);
        step();
        chk("t6_seq_sticky", seq_err, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
